rv32m_div_unit: RTL
===================

# rv32m_div_unit

Iterative 32-bit divide/remainder unit for the RV32M extension in the RV32I core. It sits between register-file read and write: it takes operands from the RD1/RD2 read ports and returns its result through the RA/WA3/WD3/WE3-style single write port. The execute stage stalls while the unit is busy. Its writeback request is arbitrated into the register-file write port one cycle at a time.

## Interface
- XLEN, 32, operand/result width (only 32 supported)
- AW, 5, register address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (op[0]=1 → unsigned)
- rs1_data  in  32  dividend (from RD1)
- rs2_data  in  32  divisor (from RD2)
- rd_addr  in  5  destination register
- flush  in  1  synchronous abort (pipeline redirect)
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse in WB state
- wb_we  out  1  write enable to register file (WE3)
- wb_addr  out  5  write address (WA3)
- wb_data  out  32  write data (WD3)

## Operation
- States: IDLE, CHECK, DIVIDE, FIXUP, WB.
- IDLE: start=1 and flush=0 → latch op, operands, and rd_addr → CHECK. Start while busy=1 is ignored, not queued.
- CHECK:
  - Divisor=0 → result: quotient 0xFFFFFFFF, remainder = dividend; → WB.
  - Signed, dividend 0x80000000, divisor 0xFFFFFFFF → quotient 0x80000000, remainder 0; → WB.
  - Otherwise take absolute values when signed, clear the 6-bit iteration counter, and go → DIVIDE.
- DIVIDE: one restoring shift-subtract step per cycle, MSB first. After 32 steps (counter 31 → wrap) → FIXUP.
- FIXUP (signed ops only; unsigned ops pass through unchanged):
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend was negative.
  - → WB.
- WB: done=1, and wb_data = quotient (op[1]=0) or remainder (op[1]=1).
  - wb_we=1 only if rd_addr≠0. For rd_addr=0, done still pulses but there is no write.
  - → IDLE.
- flush=1 in any state → IDLE on the next edge. No wb_we, no done. flush has priority over start and over WB.
- Reset (asynchronous): state IDLE; busy, done, wb_we = 0; wb_addr, wb_data = 0; internal registers = 0.
- wb_addr and wb_data are held at the last written value outside WB. Only wb_we qualifies them.

## Timing
- Edge E0 accepts start. Normal operation: CHECK after E0, DIVIDE after E1, FIXUP after E33, WB after E34, IDLE after E35.
- wb_we/done are high in the cycle after E34, so the normal latency is 34 edges.
- Fast path (divide by zero, overflow, cache hit): WB after E1, so the latency is 1 edge.
- busy rises after E0 and falls after the edge that leaves WB. The earliest next start is accepted at E36 (normal) or E3 (fast path).
- Outputs are registered state decodes. There are no combinational paths from inputs to outputs.

## Configuration
- DIV_RESULT_CACHE_EN defined:
  - The unit keeps the last completed dividend, divisor, signedness, quotient, and remainder, plus a valid bit.
  - In CHECK, a start whose operands and signedness match a valid entry takes the fast path using the cached result. This is the DIV-then-REM idiom.
  - The valid bit is cleared by reset and by flush. It is set in WB of every non-flushed operation.
- Undefined: no cache storage. Every non-special operation takes the full 34-edge latency.

## Test plan
- DIVU 100/7, rd=5 → wb_we pulse 34 edges after start, wb_addr=5, wb_data=14. Then REMU with the same operands → wb_data=2.
- REM 0xFFFFFFF9 (−7) / 2 → wb_data=0xFFFFFFFF. DIV with the same operands → 0xFFFFFFFD.
- DIV 123/0 → 0xFFFFFFFF. REM 123/0 → 123. Both at 1-edge latency.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0. Both at 1-edge latency.
- Abort and reset cases:
  - flush at edge E10 of a DIVU → busy=0 after E10, no wb_we.
  - start held during busy → ignored.
  - rd_addr=0 → done pulses, wb_we=0.
  - rst_n low mid-DIVIDE → all outputs 0 immediately, without waiting for a clock edge.
- DIV 1000/3 followed by REM 1000/3:
  - With DIV_RESULT_CACHE_EN: REM returns 1 at 1-edge latency.
  - Without DIV_RESULT_CACHE_EN: REM returns 1 at 34-edge latency.
  - With the cache and an intervening flush: REM returns 1 at 34-edge latency.

Source files
------------

// File: rtl/rv32m_div_unit.sv
// RV32M DIV/DIVU/REM/REMU: 32-cycle restoring divider, 34-edge latency (1 edge for /0, overflow, cache hit).
// Execute stalls on busy; start is ignored while busy. DIV_RESULT_CACHE_EN adds a last-result cache.
module rv32m_div_unit #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIVIDE, S_FIXUP, S_WB} state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, q_q, q_d, r_q, r_d, dv_q, dv_d;
    logic [XLEN-1:0] wbd_q, wbd_d;
    logic [AW-1:0]   wba_q, wba_d;
    logic            we_q, we_d, done_q, done_d;

    logic            sgn, go_wb;
    logic [XLEN:0]   r_sh, diff;
    logic [XLEN-1:0] fq, fr;

    assign sgn  = ~op_q[0];
    // q_q doubles as the dividend shift register: its MSB feeds the partial remainder.
    assign r_sh = {r_q, q_q[XLEN-1]};
    assign diff = r_sh - {1'b0, dv_q};

`ifdef DIV_RESULT_CACHE_EN
    logic            cv_q, cv_d, cs_q, cs_d, hit;
    logic [XLEN-1:0] ca_q, ca_d, cb_q, cb_d, cq_q, cq_d, cr_q, cr_d;
    assign hit = cv_q && (ca_q == a_q) && (cb_q == b_q) && (cs_q == sgn);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        q_d     = q_q;
        r_d     = r_q;
        dv_d    = dv_q;
        wbd_d   = wbd_q;
        wba_d   = wba_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        go_wb   = 1'b0;
        fq      = q_q;
        fr      = r_q;
`ifdef DIV_RESULT_CACHE_EN
        cv_d = cv_q;
        cs_d = cs_q;
        ca_d = ca_q;
        cb_d = cb_q;
        cq_d = cq_q;
        cr_d = cr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    rd_d    = rd_addr;
                    a_d     = rs1_data;
                    b_d     = rs2_data;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (b_q == '0) begin
                    fq    = {XLEN{1'b1}};
                    fr    = a_q;
                    go_wb = 1'b1;
                end else if (sgn && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == {XLEN{1'b1}})) begin
                    fq    = a_q;
                    fr    = '0;
                    go_wb = 1'b1;
`ifdef DIV_RESULT_CACHE_EN
                end else if (hit) begin
                    fq    = cq_q;
                    fr    = cr_q;
                    go_wb = 1'b1;
`endif
                end else begin
                    q_d     = (sgn && a_q[XLEN-1]) ? -a_q : a_q;
                    dv_d    = (sgn && b_q[XLEN-1]) ? -b_q : b_q;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (!diff[XLEN]) begin
                    r_d = diff[XLEN-1:0];
                    q_d = {q_q[XLEN-2:0], 1'b1};
                end else begin
                    r_d = r_sh[XLEN-1:0];
                    q_d = {q_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = '0;
                    state_d = S_FIXUP;
                end
            end
            S_FIXUP: begin
                fq    = (sgn && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -q_q : q_q;
                fr    = (sgn && a_q[XLEN-1]) ? -r_q : r_q;
                go_wb = 1'b1;
            end
            S_WB: begin
                state_d = S_IDLE;
`ifdef DIV_RESULT_CACHE_EN
                cv_d = 1'b1;
                cs_d = sgn;
                ca_d = a_q;
                cb_d = b_q;
                cq_d = q_q;
                cr_d = r_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (go_wb) begin
            q_d     = fq;
            r_d     = fr;
            state_d = S_WB;
            done_d  = 1'b1;
            we_d    = (rd_q != '0);
            if (rd_q != '0) begin
                wba_d = rd_q;
                wbd_d = op_q[1] ? fr : fq;
            end
        end

        // Redirect wins over everything, including a result about to be written.
        if (flush) begin
            state_d = S_IDLE;
            we_d    = 1'b0;
            done_d  = 1'b0;
            wba_d   = wba_q;
            wbd_d   = wbd_q;
`ifdef DIV_RESULT_CACHE_EN
            cv_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dv_q    <= '0;
            wbd_q   <= '0;
            wba_q   <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_RESULT_CACHE_EN
            cv_q <= 1'b0;
            cs_q <= 1'b0;
            ca_q <= '0;
            cb_q <= '0;
            cq_q <= '0;
            cr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dv_q    <= dv_d;
            wbd_q   <= wbd_d;
            wba_q   <= wba_d;
            we_q    <= we_d;
            done_q  <= done_d;
`ifdef DIV_RESULT_CACHE_EN
            cv_q <= cv_d;
            cs_q <= cs_d;
            ca_q <= ca_d;
            cb_q <= cb_d;
            cq_q <= cq_d;
            cr_q <= cr_d;
`endif
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign wb_we   = we_q;
    assign wb_addr = wba_q;
    assign wb_data = wbd_q;

endmodule
